// File: rtl/axi_read_arbiter_pkg.sv
// Shared types and AXI constants for the icache/dcache read arbiter.
package axi_arb_pkg;

  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;

  localparam logic [AXI_BURST_W-1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;

endpackage

// File: rtl/axi_read_arbiter_if.sv
// Bundle of requester-side and master-side AXI read signals around the arbiter.
interface axi_read_arbiter_if
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);

  logic                   ic_arvalid, dc_arvalid;
  logic [ADDR_W-1:0]      ic_araddr, dc_araddr;
  logic [AXI_LEN_W-1:0]   ic_arlen, dc_arlen;
  logic [AXI_SIZE_W-1:0]  ic_arsize, dc_arsize;
  logic [AXI_BURST_W-1:0] ic_arburst, dc_arburst;
  logic                   ic_arready, dc_arready;
  logic                   ic_rvalid, dc_rvalid;
  logic [DATA_W-1:0]      ic_rdata, dc_rdata;
  logic                   ic_rlast, dc_rlast;
  logic                   ic_rready, dc_rready;

  logic                   m_axi_arvalid;
  logic [ADDR_W-1:0]      m_axi_araddr;
  logic [AXI_LEN_W-1:0]   m_axi_arlen;
  logic [AXI_SIZE_W-1:0]  m_axi_arsize;
  logic [AXI_BURST_W-1:0] m_axi_arburst;
  logic                   m_axi_arready;
  logic                   m_axi_rvalid;
  logic [DATA_W-1:0]      m_axi_rdata;
  logic                   m_axi_rlast;
  logic                   m_axi_rready;

  logic                   ic_owner, dc_owner;
  logic                   len_error;

  // Arbiter side
  modport master (
    input  ic_arvalid, dc_arvalid, ic_araddr, dc_araddr, ic_arlen, dc_arlen,
           ic_arsize, dc_arsize, ic_arburst, dc_arburst, ic_rready, dc_rready,
           m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rlast,
    output ic_arready, dc_arready, ic_rvalid, dc_rvalid, ic_rdata, dc_rdata,
           ic_rlast, dc_rlast, m_axi_arvalid, m_axi_araddr, m_axi_arlen,
           m_axi_arsize, m_axi_arburst, m_axi_rready, ic_owner, dc_owner, len_error
  );

  // Caches plus downstream slave
  modport slave (
    output ic_arvalid, dc_arvalid, ic_araddr, dc_araddr, ic_arlen, dc_arlen,
           ic_arsize, dc_arsize, ic_arburst, dc_arburst, ic_rready, dc_rready,
           m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rlast,
    input  ic_arready, dc_arready, ic_rvalid, dc_rvalid, ic_rdata, dc_rdata,
           ic_rlast, dc_rlast, m_axi_arvalid, m_axi_araddr, m_axi_arlen,
           m_axi_arsize, m_axi_arburst, m_axi_rready, ic_owner, dc_owner, len_error
  );

endinterface

// File: rtl/axi_read_arbiter_picker.sv
// Winner selection between icache and dcache requests.
// With ARB_ROUND_ROBIN_EN a tie goes to whoever was not granted last; otherwise dcache wins ties.
module axi_arb_picker
  import axi_arb_pkg::*;
(
  input  logic   ic_req,
  input  logic   dc_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_e last_grant,
`endif
  output owner_e winner
);

  // Combinational priority decision
  always_comb begin
    winner = OWN_IC;
    if (ic_req && dc_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = (last_grant == OWN_IC) ? OWN_DC : OWN_IC;
`else
      winner = OWN_DC;
`endif
    end else if (dc_req) begin
      winner = OWN_DC;
    end else begin
      winner = OWN_IC;
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read master between icache and dcache, one full burst per grant.
// Optional round-robin tie breaking is enabled by defining ARB_ROUND_ROBIN_EN.
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic clock,
  input  logic reset,
  axi_read_arbiter_if.master bus
);

  arb_state_e state_q, state_d;
  owner_e     grant_q, grant_d;
  logic [AXI_LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [AXI_LEN_W-1:0] exp_len_q, exp_len_d;
  logic       len_error_q, len_error_d;
`ifdef ARB_ROUND_ROBIN_EN
  owner_e     last_grant_q, last_grant_d;
`endif

  owner_e                 pick;
  logic                   own_arvalid;
  logic [ADDR_W-1:0]      own_araddr;
  logic [AXI_LEN_W-1:0]   own_arlen;
  logic [AXI_SIZE_W-1:0]  own_arsize;
  logic [AXI_BURST_W-1:0] own_arburst;
  logic                   own_rready;
  logic                   beat;
  logic [DATA_W-1:0]      rdata;

  axi_arb_picker u_picker (
    .ic_req     (bus.ic_arvalid),
    .dc_req     (bus.dc_arvalid),
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant (last_grant_q),
`endif
    .winner     (pick)
  );

  // Select the current owner's request fields
  always_comb begin
    if (grant_q == OWN_DC) begin
      own_arvalid = bus.dc_arvalid;
      own_araddr  = bus.dc_araddr;
      own_arlen   = bus.dc_arlen;
      own_arsize  = bus.dc_arsize;
      own_arburst = bus.dc_arburst;
      own_rready  = bus.dc_rready;
    end else begin
      own_arvalid = bus.ic_arvalid;
      own_araddr  = bus.ic_araddr;
      own_arlen   = bus.ic_arlen;
      own_arsize  = bus.ic_arsize;
      own_arburst = bus.ic_arburst;
      own_rready  = bus.ic_rready;
    end
    beat  = (state_q == DATA) && bus.m_axi_rvalid && own_rready;
    rdata = bus.m_axi_rdata;
  end

  // Next-state, beat counting and length checking
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    beat_cnt_d   = beat_cnt_q;
    exp_len_d    = exp_len_q;
    len_error_d  = len_error_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.ic_arvalid || bus.dc_arvalid) begin
          grant_d = pick;
          state_d = ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        if (!own_arvalid) begin
          state_d = IDLE;
        end else if (bus.m_axi_arready) begin
          exp_len_d  = own_arlen;
          beat_cnt_d = 8'd0;
          state_d    = DATA;
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          // rlast early/late and missing rlast at the expected index are both errors
          if (bus.m_axi_rlast) begin
            if (beat_cnt_q != exp_len_q) begin
              len_error_d = 1'b1;
            end else begin
              len_error_d = len_error_q;
            end
            state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_d = grant_q;
`endif
          end else begin
            if (beat_cnt_q == exp_len_q) begin
              len_error_d = 1'b1;
            end else begin
              len_error_d = len_error_q;
            end
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= OWN_IC;
      beat_cnt_q   <= 8'd0;
      exp_len_q    <= 8'd0;
      len_error_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= OWN_IC;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      beat_cnt_q   <= beat_cnt_d;
      exp_len_q    <= exp_len_d;
      len_error_q  <= len_error_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Output decode from the registered state and grant
  always_comb begin
    bus.m_axi_arvalid = 1'b0;
    bus.m_axi_araddr  = '0;
    bus.m_axi_arlen   = 8'd0;
    bus.m_axi_arsize  = 3'd0;
    bus.m_axi_arburst = 2'd0;
    bus.m_axi_rready  = 1'b0;
    bus.ic_arready    = 1'b0;
    bus.dc_arready    = 1'b0;
    bus.ic_rvalid     = 1'b0;
    bus.dc_rvalid     = 1'b0;
    bus.ic_rlast      = 1'b0;
    bus.dc_rlast      = 1'b0;
    bus.ic_rdata      = rdata;
    bus.dc_rdata      = rdata;
    bus.ic_owner      = (state_q != IDLE) && (grant_q == OWN_IC);
    bus.dc_owner      = (state_q != IDLE) && (grant_q == OWN_DC);
    bus.len_error     = len_error_q;
    case (state_q)
      ADDR: begin
        bus.m_axi_arvalid = own_arvalid;
        bus.m_axi_araddr  = own_araddr;
        bus.m_axi_arlen   = own_arlen;
        bus.m_axi_arsize  = own_arsize;
        bus.m_axi_arburst = own_arburst;
        bus.ic_arready    = (grant_q == OWN_IC) && bus.m_axi_arready;
        bus.dc_arready    = (grant_q == OWN_DC) && bus.m_axi_arready;
      end
      DATA: begin
        bus.m_axi_rready = own_rready;
        bus.ic_rvalid    = (grant_q == OWN_IC) && bus.m_axi_rvalid;
        bus.dc_rvalid    = (grant_q == OWN_DC) && bus.m_axi_rvalid;
        bus.ic_rlast     = (grant_q == OWN_IC) && bus.m_axi_rlast;
        bus.dc_rlast     = (grant_q == OWN_DC) && bus.m_axi_rlast;
      end
      default: begin
        bus.m_axi_arvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench: bench plays both caches and the AXI slave; a transaction-level model predicts grants and len_error.
module tb_axi_read_arbiter;
  import axi_arb_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  axi_read_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  axi_read_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Model state: requests per owner (0 = icache, 1 = dcache), last grant, sticky error
  logic [63:0] req_addr [2];
  logic [7:0]  req_len  [2];
  int          req_last [2];
  int          model_last;
  bit          model_err;

  // Observations returned by serve()
  int          o_got, o_wait, o_beats, o_stray;
  logic [63:0] o_addr;
  logic [7:0]  o_len;
  logic [2:0]  o_size;
  bit          o_idle;

  function automatic int tie_winner();
`ifdef ARB_ROUND_ROBIN_EN
    return (model_last == 0) ? 1 : 0;
`else
    return 1;
`endif
  endfunction

  task automatic clear_inputs();
    bus.ic_arvalid = 1'b0; bus.dc_arvalid = 1'b0;
    bus.ic_araddr = 64'd0; bus.dc_araddr = 64'd0;
    bus.ic_arlen = 8'd0; bus.dc_arlen = 8'd0;
    bus.ic_arsize = 3'd3; bus.dc_arsize = 3'd2;
    bus.ic_arburst = BURST_INCR; bus.dc_arburst = BURST_INCR;
    bus.ic_rready = 1'b0; bus.dc_rready = 1'b0;
    bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rdata = 64'd0; bus.m_axi_rlast = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_last = 0;
    model_err  = 1'b0;
  endtask

  task automatic set_req(input int who, input logic [63:0] addr, input logic [7:0] len, input int last);
    req_addr[who] = addr; req_len[who] = len; req_last[who] = last;
    if (who == 1) begin
      bus.dc_araddr = addr; bus.dc_arlen = len; bus.dc_arvalid = 1'b1;
    end else begin
      bus.ic_araddr = addr; bus.ic_arlen = len; bus.ic_arvalid = 1'b1;
    end
  endtask

  // Act as slave for one granted burst; rlast is given on beat req_last[owner]
  task automatic serve(input int ar_delay, input bit bp);
    logic [63:0] beat_data;
    bit rr, acc, own_rdy;
    int b, n, cyc;
    o_got = -1; o_wait = 0; o_beats = 0; o_stray = 0; o_idle = 1'b0;
    o_addr = 64'd0; o_len = 8'd0; o_size = 3'd0;
    while (o_wait < 20) begin
      @(negedge clock);
      if (bus.m_axi_arvalid === 1'b1) break;
      o_wait++;
    end
    if (bus.m_axi_arvalid !== 1'b1) return;
    o_got  = (bus.dc_owner === 1'b1) ? 1 : 0;
    o_addr = bus.m_axi_araddr; o_len = bus.m_axi_arlen; o_size = bus.m_axi_arsize;
    repeat (ar_delay) @(posedge clock);
    #1 bus.m_axi_arready = 1'b1;
    #1;
    if (o_got == 1) begin
      if (bus.dc_arready !== 1'b1 || bus.ic_arready !== 1'b0) o_stray++;
    end else begin
      if (bus.ic_arready !== 1'b1 || bus.dc_arready !== 1'b0) o_stray++;
    end
    @(posedge clock); #1;
    bus.m_axi_arready = 1'b0;
    if (o_got == 1) bus.dc_arvalid = 1'b0; else bus.ic_arvalid = 1'b0;
    n = req_last[o_got]; b = 1; cyc = 0; rr = 1'b1;
    while (b <= n && cyc < 400) begin
      beat_data = {$urandom, $urandom};
      bus.m_axi_rvalid = 1'b1; bus.m_axi_rdata = beat_data; bus.m_axi_rlast = (b == n);
      own_rdy = bp ? rr : 1'b1;
      rr = ~rr;
      if (o_got == 1) bus.dc_rready = own_rdy; else bus.ic_rready = own_rdy;
      @(negedge clock);
      acc = 1'b0;
      if (bus.m_axi_rready !== own_rdy) o_stray++;
      if (bus.ic_rdata !== beat_data || bus.dc_rdata !== beat_data) o_stray++;
      if (o_got == 1) begin
        if (bus.ic_rvalid !== 1'b0 || bus.ic_rlast !== 1'b0 || bus.ic_arready !== 1'b0 || bus.dc_owner !== 1'b1) o_stray++;
        if (bus.dc_rlast !== (b == n)) o_stray++;
        acc = (bus.dc_rvalid === 1'b1) && own_rdy;
      end else begin
        if (bus.dc_rvalid !== 1'b0 || bus.dc_rlast !== 1'b0 || bus.dc_arready !== 1'b0 || bus.ic_owner !== 1'b1) o_stray++;
        if (bus.ic_rlast !== (b == n)) o_stray++;
        acc = (bus.ic_rvalid === 1'b1) && own_rdy;
      end
      if (acc) o_beats++;
      @(posedge clock); #1;
      if (acc) b++;
      cyc++;
    end
    bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0;
    bus.ic_rready = 1'b0; bus.dc_rready = 1'b0;
    @(negedge clock);
    o_idle = (bus.ic_owner === 1'b0) && (bus.dc_owner === 1'b0) && (bus.m_axi_arvalid === 1'b0);
  endtask

  task automatic test_reset();
    logic [10:0] outs;
    @(posedge clock); #1;
    clear_inputs();
    reset = 1'b1;
    bus.ic_arvalid = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    outs = {bus.m_axi_arvalid, bus.m_axi_rready, bus.ic_arready, bus.dc_arready, bus.ic_rvalid,
            bus.dc_rvalid, bus.ic_rlast, bus.dc_rlast, bus.ic_owner, bus.dc_owner, bus.len_error};
    n_cmp++;
    if (outs !== 11'd0) begin n_bad++; $display("FAIL reset_outputs: got %b expected 0", outs); end
    n_cmp++;
    if (bus.m_axi_araddr !== 64'd0) begin n_bad++; $display("FAIL reset_araddr: got %h expected 0", bus.m_axi_araddr); end
    #1 reset = 1'b0;
    bus.ic_arvalid = 1'b0;
    model_last = 0; model_err = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single_ic();
    do_reset();
    set_req(0, 64'h1000, 8'd7, 8);
    serve(2, 1'b0);
    n_cmp++; if (o_got !== 0) begin n_bad++; $display("FAIL single_owner: got %0d expected 0", o_got); end
    n_cmp++; if (o_wait !== 1) begin n_bad++; $display("FAIL single_latency: got %0d expected 1", o_wait); end
    n_cmp++; if (o_addr !== 64'h1000) begin n_bad++; $display("FAIL single_araddr: got %h expected 1000", o_addr); end
    n_cmp++; if (o_len !== 8'd7) begin n_bad++; $display("FAIL single_arlen: got %0d expected 7", o_len); end
    n_cmp++; if (o_beats !== 8) begin n_bad++; $display("FAIL single_beats: got %0d expected 8", o_beats); end
    n_cmp++; if (o_stray !== 0) begin n_bad++; $display("FAIL single_routing: got %0d bad cycles expected 0", o_stray); end
    n_cmp++; if (o_idle !== 1'b1) begin n_bad++; $display("FAIL single_idle: got %0d expected 1", o_idle); end
    n_cmp++; if (bus.len_error !== 1'b0) begin n_bad++; $display("FAIL single_len_error: got %0d expected 0", bus.len_error); end
    model_last = 0;
  endtask

  task automatic test_abort();
    do_reset();
    set_req(0, 64'h2000, 8'd3, 4);
    @(negedge clock); @(negedge clock);
    bus.ic_arvalid = 1'b0;
    #1;
    n_cmp++; if (bus.m_axi_arvalid !== 1'b0) begin n_bad++; $display("FAIL abort_arvalid: got %0d expected 0", bus.m_axi_arvalid); end
    @(negedge clock);
    n_cmp++; if (bus.ic_owner !== 1'b0) begin n_bad++; $display("FAIL abort_owner: got %0d expected 0", bus.ic_owner); end
  endtask

  task automatic test_tie();
    int w, l;
    do_reset();
    for (int t = 0; t < 3; t++) begin
      set_req(0, 64'h4000 + 64'(t * 256), 8'(t + 1), t + 2);
      set_req(1, 64'h8000 + 64'(t * 256), 8'(t + 2), t + 3);
      w = tie_winner(); l = 1 - w;
      serve(1, 1'b0);
      n_cmp++; if (o_got !== w) begin n_bad++; $display("FAIL tie%0d_first: got %0d expected %0d", t, o_got, w); end
      n_cmp++; if (o_addr !== req_addr[w]) begin n_bad++; $display("FAIL tie%0d_addr: got %h expected %h", t, o_addr, req_addr[w]); end
      model_last = w;
      serve(0, 1'b0);
      n_cmp++; if (o_got !== l) begin n_bad++; $display("FAIL tie%0d_second: got %0d expected %0d", t, o_got, l); end
      n_cmp++; if (o_wait !== 0) begin n_bad++; $display("FAIL tie%0d_regrant: got %0d expected 0", t, o_wait); end
      n_cmp++; if (o_beats !== req_last[l]) begin n_bad++; $display("FAIL tie%0d_beats: got %0d expected %0d", t, o_beats, req_last[l]); end
      model_last = l;
    end
  endtask

  task automatic test_len_error();
    do_reset();
    set_req(0, 64'h3000, 8'd7, 5);
    serve(0, 1'b0);
    n_cmp++; if (bus.len_error !== 1'b1) begin n_bad++; $display("FAIL early_rlast_err: got %0d expected 1", bus.len_error); end
    n_cmp++; if (o_idle !== 1'b1) begin n_bad++; $display("FAIL early_rlast_idle: got %0d expected 1", o_idle); end
    n_cmp++; if (o_beats !== 5) begin n_bad++; $display("FAIL early_rlast_beats: got %0d expected 5", o_beats); end
    do_reset();
    set_req(1, 64'h5000, 8'd3, 6);
    serve(0, 1'b0);
    n_cmp++; if (bus.len_error !== 1'b1) begin n_bad++; $display("FAIL late_rlast_err: got %0d expected 1", bus.len_error); end
    n_cmp++; if (o_beats !== 6) begin n_bad++; $display("FAIL late_rlast_beats: got %0d expected 6", o_beats); end
    n_cmp++; if (o_stray !== 0) begin n_bad++; $display("FAIL late_rlast_held: got %0d bad cycles expected 0", o_stray); end
    model_last = 1; model_err = 1'b1;
  endtask

  // Entered with len_error still set, so the reset really has to clear it
  task automatic test_reset_mid();
    logic [10:0] outs;
    int k;
    set_req(0, 64'h6000, 8'd7, 8);
    k = 0;
    while (k < 20 && bus.m_axi_arvalid !== 1'b1) begin @(negedge clock); k++; end
    #1 bus.m_axi_arready = 1'b1;
    @(posedge clock); #1;
    bus.m_axi_arready = 1'b0; bus.ic_arvalid = 1'b0;
    bus.m_axi_rvalid = 1'b1; bus.ic_rready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    bus.m_axi_rvalid = 1'b0; bus.ic_rready = 1'b0;
    model_last = 0; model_err = 1'b0;
    @(negedge clock);
    outs = {bus.m_axi_arvalid, bus.m_axi_rready, bus.ic_arready, bus.dc_arready, bus.ic_rvalid,
            bus.dc_rvalid, bus.ic_rlast, bus.dc_rlast, bus.ic_owner, bus.dc_owner, bus.len_error};
    n_cmp++; if (outs !== 11'd0) begin n_bad++; $display("FAIL midreset_outputs: got %b expected 0", outs); end
    set_req(1, 64'h7000, 8'd3, 4);
    serve(0, 1'b0);
    n_cmp++; if (o_got !== 1) begin n_bad++; $display("FAIL midreset_regrant: got %0d expected 1", o_got); end
    n_cmp++; if (o_beats !== 4) begin n_bad++; $display("FAIL midreset_beats: got %0d expected 4", o_beats); end
    n_cmp++; if (bus.len_error !== 1'b0) begin n_bad++; $display("FAIL midreset_len_error: got %0d expected 0", bus.len_error); end
    model_last = 1;
  endtask

  task automatic test_backpressure();
    set_req(0, 64'h9000, 8'd7, 8);
    serve(1, 1'b1);
    n_cmp++; if (o_got !== 0) begin n_bad++; $display("FAIL bp_owner: got %0d expected 0", o_got); end
    n_cmp++; if (o_beats !== 8) begin n_bad++; $display("FAIL bp_beats: got %0d expected 8", o_beats); end
    n_cmp++; if (o_stray !== 0) begin n_bad++; $display("FAIL bp_mirror: got %0d bad cycles expected 0", o_stray); end
    n_cmp++; if (bus.len_error !== 1'b0) begin n_bad++; $display("FAIL bp_len_error: got %0d expected 0", bus.len_error); end
    model_last = 0;
  endtask

  task automatic test_random();
    int c, first, exp_o, npend, len;
    do_reset();
    for (int it = 0; it < 14; it++) begin
      c = $urandom_range(0, 2);
      for (int who = 0; who < 2; who++) begin
        if (c == 2 || c == who) begin
          len = $urandom_range(0, 7);
          set_req(who, {$urandom, $urandom}, 8'(len),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, len + 3) : len + 1);
        end
      end
      first = (c == 2) ? tie_winner() : c;
      npend = (c == 2) ? 2 : 1;
      for (int k = 0; k < npend; k++) begin
        exp_o = (k == 0) ? first : 1 - first;
        serve($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        if (req_last[exp_o] != int'(req_len[exp_o]) + 1) model_err = 1'b1;
        n_cmp++; if (o_got !== exp_o) begin n_bad++; $display("FAIL rnd%0d_owner: got %0d expected %0d", it, o_got, exp_o); end
        n_cmp++; if (o_addr !== req_addr[exp_o] || o_len !== req_len[exp_o] || o_size !== ((exp_o == 1) ? 3'd2 : 3'd3))
          begin n_bad++; $display("FAIL rnd%0d_ar: got %h/%0d/%0d expected %h/%0d", it, o_addr, o_len, o_size, req_addr[exp_o], req_len[exp_o]); end
        n_cmp++; if (o_beats !== req_last[exp_o]) begin n_bad++; $display("FAIL rnd%0d_beats: got %0d expected %0d", it, o_beats, req_last[exp_o]); end
        n_cmp++; if (o_stray !== 0) begin n_bad++; $display("FAIL rnd%0d_routing: got %0d bad cycles expected 0", it, o_stray); end
        n_cmp++; if (bus.len_error !== model_err) begin n_bad++; $display("FAIL rnd%0d_len_error: got %0d expected %0d", it, bus.len_error, model_err); end
        model_last = exp_o;
      end
    end
  endtask

  initial begin
    clear_inputs();
    model_last = 0; model_err = 1'b0;
    test_reset();
    test_single_ic();
    test_abort();
    test_tie();
    test_len_error();
    test_reset_mid();
    test_backpressure();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
